// File: rtl/uart_tx_dois_bytes_pkg.sv
// Shared definitions for the two-byte UART pair (RX and TX): FSM encoding and timing defaults.
// The state numbering matches the receiver so both decode identically in debug views.
package uart_tx_dois_bytes_pkg;

    typedef enum logic [2:0] {
        OCIOSO  = 3'b000,
        START   = 3'b001,
        DADOS   = 3'b010,
        STOP    = 3'b011,
        LIMPEZA = 3'b100
    } estado_t;

    localparam int CLOCKS_POR_BIT_PADRAO = 5209;  // 50 MHz / 9600 baud
    localparam int CONTADOR_W            = 13;

endpackage

// File: rtl/uart_tx_dois_bytes.sv
// UART 8N1 transmitter, LSB first, idle high. One accepted start sends one byte,
// or two bytes back-to-back with no idle gap between them.
module uart_tx_dois_bytes
    import uart_tx_dois_bytes_pkg::*;
#(
    parameter int CLOCKS_POR_BIT = CLOCKS_POR_BIT_PADRAO
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciarEnvio,
    input  logic       enviarDoisBytes,
    input  logic [7:0] primeiroByte,
    input  logic [7:0] segundoByte,
    output logic       bitSerialSaida,
    output logic       transmissaoAtiva,
    output logic       transmissaoConcluida
);

    localparam logic [CONTADOR_W-1:0] CONT_FIM = CONTADOR_W'(CLOCKS_POR_BIT - 1);

    estado_t               estado_q;
    logic [CONTADOR_W-1:0] cont_q;
    logic [2:0]            indice_q;
    logic                  sel_q;
    logic                  dois_q;
    logic [7:0]            byte0_q;
    logic [7:0]            byte1_q;
    logic                  linha_q;
    logic                  ativa_q;
    logic                  concluida_q;

    logic [7:0] byte_atual;
    logic       fim_bit;

    assign byte_atual = sel_q ? byte1_q : byte0_q;
    assign fim_bit    = (cont_q == CONT_FIM);

    assign bitSerialSaida       = linha_q;
    assign transmissaoAtiva     = ativa_q;
    assign transmissaoConcluida = concluida_q;

    // Outputs are written alongside the state so the line level always matches the state being entered.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q    <= OCIOSO;
            cont_q      <= '0;
            indice_q    <= '0;
            sel_q       <= 1'b0;
            dois_q      <= 1'b0;
            byte0_q     <= '0;
            byte1_q     <= '0;
            linha_q     <= 1'b1;
            ativa_q     <= 1'b0;
            concluida_q <= 1'b0;
        end else begin
            case (estado_q)
                OCIOSO: begin
                    cont_q      <= '0;
                    concluida_q <= 1'b0;
                    if (iniciarEnvio) begin
                        byte0_q  <= primeiroByte;
                        byte1_q  <= segundoByte;
                        dois_q   <= enviarDoisBytes;
                        sel_q    <= 1'b0;
                        indice_q <= '0;
                        estado_q <= START;
                        linha_q  <= 1'b0;
                        ativa_q  <= 1'b1;
                    end else begin
                        linha_q <= 1'b1;
                        ativa_q <= 1'b0;
                    end
                end
                START: begin
                    if (fim_bit) begin
                        cont_q   <= '0;
                        indice_q <= '0;
                        estado_q <= DADOS;
                        linha_q  <= byte_atual[0];
                    end else begin
                        cont_q <= cont_q + 1'b1;
                    end
                end
                DADOS: begin
                    if (fim_bit) begin
                        cont_q <= '0;
                        if (indice_q == 3'd7) begin
                            estado_q <= STOP;
                            linha_q  <= 1'b1;
                        end else begin
                            indice_q <= indice_q + 3'd1;
                            linha_q  <= byte_atual[indice_q + 3'd1];
                        end
                    end else begin
                        cont_q <= cont_q + 1'b1;
                    end
                end
                STOP: begin
                    if (fim_bit) begin
                        cont_q <= '0;
                        // Second byte follows the first stop bit directly.
                        if (!sel_q && dois_q) begin
                            sel_q    <= 1'b1;
                            indice_q <= '0;
                            estado_q <= START;
                            linha_q  <= 1'b0;
                        end else begin
                            estado_q    <= LIMPEZA;
                            linha_q     <= 1'b1;
                            concluida_q <= 1'b1;
                        end
                    end else begin
                        cont_q <= cont_q + 1'b1;
                    end
                end
                LIMPEZA: begin
                    estado_q    <= OCIOSO;
                    linha_q     <= 1'b1;
                    ativa_q     <= 1'b0;
                    concluida_q <= 1'b0;
                end
                default: begin
                    estado_q    <= OCIOSO;
                    cont_q      <= '0;
                    indice_q    <= '0;
                    sel_q       <= 1'b0;
                    linha_q     <= 1'b1;
                    ativa_q     <= 1'b0;
                    concluida_q <= 1'b0;
                end
            endcase
        end
    end

endmodule
